instruction_fetch_unit: RTL

- Initiator side of the instruction-memory read interface. Owns the program counter and drives a 64-bit byte address to the combinational, read-only instruction memory.
- Waits a parameterised number of cycles for the read data to settle, then captures the 32-bit instruction into a one-entry output register. Presents that register to decode over a valid/ready handshake.
- Accepts a branch redirect (B, CBZ taken) from execute, which flushes the output register.

---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 78 +++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch <-> instruction memory / decode / execute signal bundle.
// master = fetch unit, slave = memory, decode and redirect sources.
interface instruction_fetch_unit_if;
   logic [63:0] IMemAddress;
   logic [31:0] IMemData;
   logic [31:0] Instruction;
   logic [63:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic        BranchTaken;
   logic [63:0] BranchTarget;
   logic [31:0] FetchCount;

   modport master (
      output IMemAddress, Instruction, InstrPC,
      output InstrValid, FetchCount,
      input  IMemData, InstrReady,
      input  BranchTaken, BranchTarget
   );

   modport slave (
      input  IMemAddress, Instruction, InstrPC,
      input  InstrValid, FetchCount,
      output IMemData, InstrReady,
      output BranchTaken, BranchTarget
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, waits READ_WAIT cycles on the
// combinational memory, then offers one word at a time to decode.
module instruction_fetch_unit #(
   parameter int unsigned READ_WAIT = 2,
   parameter logic [63:0] START_PC  = 64'h0
) (
   input logic CLK,
   input logic Reset,
   instruction_fetch_unit_if.master bus
);
   localparam logic [3:0] SETTLE = 4'(READ_WAIT - 1);

   logic [63:0] pc, pc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] instr, instr_nxt;
   logic [63:0] ipc, ipc_nxt;
   logic        vld, vld_nxt;
   logic [31:0] fcnt, fcnt_nxt;
   logic        settled;
   logic        xfer;
   logic        capture;

   always_comb begin
      settled   = (cnt == SETTLE);
      xfer      = vld & bus.InstrReady;
      capture   = settled & (~vld | bus.InstrReady)
                & ~bus.BranchTaken;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      instr_nxt = instr;
      ipc_nxt   = ipc;
      vld_nxt   = vld;
      // decode consumed the word even if a redirect lands this cycle
      fcnt_nxt  = xfer ? fcnt + 32'd1 : fcnt;
      unique case (1'b1)
         bus.BranchTaken: begin
            pc_nxt  = bus.BranchTarget & ~64'h3;
            cnt_nxt = 4'd0;
            vld_nxt = 1'b0;
         end
         capture: begin
            instr_nxt = bus.IMemData;
            ipc_nxt   = pc;
            vld_nxt   = 1'b1;
            pc_nxt    = pc + 64'd4;
            cnt_nxt   = 4'd0;
         end
         default: begin
            if (cnt < SETTLE) cnt_nxt = cnt + 4'd1;
            if (xfer) vld_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc    <= START_PC;
         cnt   <= 4'd0;
         instr <= 32'h0;
         ipc   <= 64'h0;
         vld   <= 1'b0;
         fcnt  <= 32'h0;
      end else begin
         pc    <= pc_nxt;
         cnt   <= cnt_nxt;
         instr <= instr_nxt;
         ipc   <= ipc_nxt;
         vld   <= vld_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   assign bus.IMemAddress = pc;
   assign bus.Instruction = instr;
   assign bus.InstrPC     = ipc;
   assign bus.InstrValid  = vld;
   assign bus.FetchCount  = fcnt;
endmodule
